// File: rtl/cpu_bus_interface.sv
// ============================================================================
// Module   : cpu_bus_interface
// Purpose  : 6502 external memory interface for the NES CPU core. Runs one
//            memory read or write per request over a req/ack port. Owns the
//            Input Data Latch (DL) and the Data Output Register (DOR), and
//            raises busy so the CPU timing logic stalls until the access ends.
// Ports    : clk, reset (sync, active-high)
//            access_start/access_rw/access_addr/DB   - request from CPU control
//            mem_req/mem_we/mem_addr/mem_wdata       - memory request side
//            mem_rdata/mem_ack                       - memory response side
//            Input_Data_Latch_Out, Data_Output_Register_Out
//            busy, done, timeout                     - status to CPU control
// Config   : BUS_TIMEOUT_EN - when defined, an access that sees no ack for
//            TIMEOUT_CYCLES REQ cycles is aborted with done=timeout=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_interface #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  access_start,
   input  logic                  access_rw,
   input  logic [ADDR_WIDTH-1:0] access_addr,
   input  logic [DATA_WIDTH-1:0] DB,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [DATA_WIDTH-1:0] Input_Data_Latch_Out,
   output logic [DATA_WIDTH-1:0] Data_Output_Register_Out,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state_q,    state_d;
   logic                  mem_req_q,  mem_req_d;
   logic                  mem_we_q,   mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] dl_q,       dl_d;
   logic [DATA_WIDTH-1:0] dor_q,      dor_d;

`ifdef BUS_TIMEOUT_EN
   // One extra bit of headroom so TIMEOUT_CYCLES-1 always fits.
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`else
   // TIMEOUT_CYCLES has no effect when the watchdog is not built.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      dl_d       = dl_q;
      dor_d      = dor_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         // DONE accepts a new request exactly like IDLE so accesses can
         // run back to back without an idle gap.
         ST_IDLE, ST_DONE: begin
            if (access_start) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_we_d   = ~access_rw;
               mem_addr_d = access_addr;
               if (!access_rw) begin
                  dor_d = DB;
               end
`ifdef BUS_TIMEOUT_EN
               cnt_d = '0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // Request attributes stay frozen here; new starts are ignored.
            if (mem_ack) begin
               state_d   = ST_DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  dl_d = mem_rdata;
               end
            end
`ifdef BUS_TIMEOUT_EN
            // An ack in the final allowed cycle takes priority over abort.
            else if (cnt_q == CNT_LAST) begin
               state_d   = ST_DONE;
               mem_req_d = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         dl_q       <= '0;
         dor_q      <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         dl_q       <= dl_d;
         dor_q      <= dor_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign mem_req                  = mem_req_q;
   assign mem_we                   = mem_we_q;
   assign mem_addr                 = mem_addr_q;
   assign mem_wdata                = dor_q;
   assign Input_Data_Latch_Out     = dl_q;
   assign Data_Output_Register_Out = dor_q;
   assign busy                     = mem_req_q;
   assign done                     = (state_q == ST_DONE);
`ifdef BUS_TIMEOUT_EN
   assign timeout                  = timeout_q;
`else
   assign timeout                  = 1'b0;
`endif

endmodule

`default_nettype wire
